uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding several byte requesters into one UART transmitter.
// Also generates the baud-enable tick for that transmitter.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BAUD_DIV     = 16,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       tx_busy,
    output logic                       tx_wr_enb,
    output logic [7:0]                 tx_data,
    output logic                       baud_enb,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BAUD_DIV);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    logic [BW-1:0]  baud_cnt;
    logic [TW-1:0]  wait_cnt;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic           found;
    logic           grant_ok;
    logic           run;

    // baud_enb is registered one cycle ahead so it lines up with BAUD_DIV-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            baud_enb <= 1'b0;
        end else begin
            baud_enb <= (baud_cnt == BW'(BAUD_DIV - 2));
            if (baud_cnt == BW'(BAUD_DIV - 1)) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // run keeps req_ready low until the first edge after reset release
    assign grant_ok = run && (state == IDLE) && arb_en && !tx_busy && found;

    always_comb begin
        req_ready = '0;
        if (grant_ok) begin
            req_ready[win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            run         <= 1'b0;
            tx_wr_enb   <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= '0;
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
        end else begin
            run       <= 1'b1;
            tx_wr_enb <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_ok) begin
                        tx_data   <= req_data[{win, 3'b000} +: 8];
                        grant_id  <= win;
                        tx_wr_enb <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // the ISSUE cycle counts toward the timeout window
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == TW'(BUSY_TIMEOUT - 2)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
